// File: rtl/divider_cu_pkg.sv
// Shared types for the restoring-divider control unit: FSM states and the datapath control bundle.
// Pure declarations, no logic and no latency; no handshake lives here.
package div_pkg;

    localparam int CNT_W      = 3;
    localparam int DIV_DATA_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_SHIFT,
        S_UPDATE,
        S_DONE,
        S_ERR
    } div_state_t;

    typedef struct packed {
        logic yen;
        logic xen;
        logic ren;
        logic x_sl;
        logic xshiftbit;
        logic rsl;
        logic rsr;
        logic s1;
        logic s2;
        logic s3;
        logic load_cnt;
        logic ud;
        logic cen;
        logic busy;
        logic done;
        logic error;
    } div_ctl_t;

endpackage

// File: rtl/divider_cu_if.sv
// Requester/datapath bundle around divider_cu: go and datapath flags in, every control strobe out.
// Wires only, zero latency; go is a level request, done/error are held (or pulsed) status.
interface divider_cu_if;
    import div_pkg::*;

    logic             go;
    logic             R_lt_Y;
    logic             cnt_out;
    logic             zeroerror;
    logic             Yen;
    logic             Xen;
    logic             Ren;
    logic             X_sL;
    logic             Xshiftbit;
    logic             RsL;
    logic             RsR;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             load_cnt;
    logic             ud;
    logic             Cen;
    logic [CNT_W-1:0] n;
    logic             busy;
    logic             done;
    logic             error;

    modport slave (
        input  go, R_lt_Y, cnt_out, zeroerror,
        output Yen, Xen, Ren, X_sL, Xshiftbit, RsL, RsR, s1, s2, s3,
               load_cnt, ud, Cen, n, busy, done, error
    );

    modport master (
        output go, R_lt_Y, cnt_out, zeroerror,
        input  Yen, Xen, Ren, X_sL, Xshiftbit, RsL, RsR, s1, s2, s3,
               load_cnt, ud, Cen, n, busy, done, error
    );

endinterface

// File: rtl/divider_cu_dec.sv
// State-to-control decoder for the divider FSM (Moore, except the UPDATE quotient bit on R_lt_Y).
// Purely combinational, zero latency; no backpressure.
module divider_cu_dec
    import div_pkg::*;
(
    input  div_state_t i_state,
    input  logic       i_R_lt_Y,
    input  logic       i_result_valid,
    output div_ctl_t   o_ctl
);

    always_comb begin
        o_ctl    = '0;
        o_ctl.s2 = 1'b1;
        o_ctl.s3 = 1'b1;
        case (i_state)
            S_IDLE: begin
                // A finished quotient stays visible until the next load when pulsed-done is built in.
                o_ctl.s2 = ~i_result_valid;
                o_ctl.s3 = ~i_result_valid;
            end
            S_LOAD: begin
                o_ctl.xen      = 1'b1;
                o_ctl.yen      = 1'b1;
                o_ctl.ren      = 1'b1;
                o_ctl.s1       = 1'b1;
                o_ctl.cen      = 1'b1;
                o_ctl.load_cnt = 1'b1;
                o_ctl.busy     = 1'b1;
            end
            S_CHECK: begin
                o_ctl.busy = 1'b1;
            end
            S_SHIFT: begin
                o_ctl.rsl  = 1'b1;
                o_ctl.cen  = 1'b1;
                o_ctl.busy = 1'b1;
            end
            S_UPDATE: begin
                o_ctl.x_sl      = 1'b1;
                o_ctl.xshiftbit = ~i_R_lt_Y;
                o_ctl.ren       = ~i_R_lt_Y;
                o_ctl.busy      = 1'b1;
            end
            S_DONE: begin
                o_ctl.done = 1'b1;
                o_ctl.s2   = 1'b0;
                o_ctl.s3   = 1'b0;
            end
            S_ERR: begin
                o_ctl.done  = 1'b1;
                o_ctl.error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/divider_cu.sv
// Restoring-divider control unit: loads operands, runs N_BITS shift/subtract rounds, flags /0.
// Done 2+2*N_BITS edges after go is sampled; go ignored while busy. DIV_CU_PULSE_DONE_EN: 1-cycle done.
module divider_cu
    import div_pkg::*;
#(
    parameter int N_BITS = 4
) (
    input  logic  clk,
    input  logic  rst,
    divider_cu_if.slave bus
);

    div_state_t r_state;
    div_state_t w_next;
    div_ctl_t   w_ctl;
    logic       w_result_valid;
    logic       w_err_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.go) w_next = S_LOAD;
            S_LOAD:   w_next = S_CHECK;
            S_CHECK:  w_next = bus.zeroerror ? S_ERR : S_SHIFT;
            S_SHIFT:  w_next = S_UPDATE;
            // The counter was decremented in SHIFT, so zero here means the last round just finished.
            S_UPDATE: w_next = bus.cnt_out ? S_DONE : S_SHIFT;
            S_DONE, S_ERR: begin
`ifdef DIV_CU_PULSE_DONE_EN
                w_next = S_IDLE;
`else
                if (!bus.go) w_next = S_IDLE;
`endif
            end
            default:  w_next = S_IDLE;
        endcase
    end

`ifdef DIV_CU_PULSE_DONE_EN
    logic r_result_valid;
    logic r_err_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result_valid <= 1'b0;
            r_err_hold     <= 1'b0;
        end else if (w_next == S_LOAD) begin
            r_result_valid <= 1'b0;
            r_err_hold     <= 1'b0;
        end else begin
            if (w_next == S_DONE) r_result_valid <= 1'b1;
            if (w_next == S_ERR)  r_err_hold     <= 1'b1;
        end
    end

    assign w_result_valid = r_result_valid;
    assign w_err_hold     = r_err_hold;
`else
    assign w_result_valid = 1'b0;
    assign w_err_hold     = 1'b0;
`endif

    divider_cu_dec u_dec (
        .i_state        (r_state),
        .i_R_lt_Y       (bus.R_lt_Y),
        .i_result_valid (w_result_valid),
        .o_ctl          (w_ctl)
    );

    assign bus.Yen       = w_ctl.yen;
    assign bus.Xen       = w_ctl.xen;
    assign bus.Ren       = w_ctl.ren;
    assign bus.X_sL      = w_ctl.x_sl;
    assign bus.Xshiftbit = w_ctl.xshiftbit;
    assign bus.RsL       = w_ctl.rsl;
    assign bus.RsR       = w_ctl.rsr;
    assign bus.s1        = w_ctl.s1;
    assign bus.s2        = w_ctl.s2;
    assign bus.s3        = w_ctl.s3;
    assign bus.load_cnt  = w_ctl.load_cnt;
    assign bus.ud        = w_ctl.ud;
    assign bus.Cen       = w_ctl.cen;
    assign bus.n         = CNT_W'(N_BITS);
    assign bus.busy      = w_ctl.busy;
    assign bus.done      = w_ctl.done;
    assign bus.error     = w_ctl.error | w_err_hold;

endmodule

// File: doc/divider_cu.md
Name: divider_cu

Overview:
Control unit that sequences the 4-bit restoring-divider datapath, one quotient bit per iteration.
- Accepts a start request and loads dividend, divisor and iteration counter.
- Runs N_BITS shift/compare/subtract iterations, then presents quotient and remainder with a done flag.
- Detects divide-by-zero from the datapath flag and reports an error instead of iterating.
- Sits between the system-level requester and the divider datapath; drives every datapath control input.

Parameters:
N_BITS, 4, iterations per divide; loaded into the 3-bit counter; legal 1..7.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
go  in  1  start request, level-sampled in IDLE
R_lt_Y  in  1  datapath flag: R[3:0] < Y
cnt_out  in  1  datapath flag: iteration counter == 0
zeroerror  in  1  datapath flag: Y register == 0
Yen, Xen, Ren  out  1 each  register loads
X_sL, Xshiftbit  out  1 each  X shift-left and inserted LSB
RsL, RsR  out  1 each  R shift left/right; RsR is always 0
s1  out  1  R_in mux select; 1 selects zero
s2, s3  out  1 each  R/Q output gates; 1 forces the output to zero
load_cnt, ud, Cen  out  1 each  counter load, direction, enable
n  out  3  counter load value, constant N_BITS
busy  out  1  operation in progress
done  out  1  result valid
error  out  1  divide-by-zero

Behaviour:
- States: IDLE, LOAD, CHECK, SHIFT, UPDATE, DONE, ERR.
- Outputs are decoded from the state (Moore), except Xshiftbit and Ren in UPDATE, which depend combinationally on R_lt_Y.
- Any output not listed for a state is 0; s2 = s3 = 1 unless listed otherwise.
- rst low: state goes to IDLE immediately, including mid-operation. Reset values: all control outputs 0, s2 = s3 = 1, busy = done = error = 0.
- IDLE: if go = 1, go to LOAD.
- LOAD:
  - Xen = Yen = Ren = 1, s1 = 1 (R cleared).
  - Cen = load_cnt = 1 (counter loads N_BITS).
  - busy = 1; go to CHECK.
- CHECK: busy = 1. If zeroerror = 1, go to ERR; else go to SHIFT.
- SHIFT:
  - RsL = 1 (R takes X msb); Cen = 1, ud = 0 (counter decrements).
  - busy = 1; go to UPDATE.
- UPDATE:
  - X_sL = 1, Xshiftbit = ~R_lt_Y, Ren = ~R_lt_Y, s1 = 0 (R := R - Y when R >= Y).
  - busy = 1. If cnt_out = 1, go to DONE; else go to SHIFT.
- DONE: done = 1, s2 = s3 = 0. Hold while go = 1; go = 0 returns to IDLE.
- ERR: done = error = 1, s2 = s3 = 1 (Q = R = 0). Hold while go = 1; go = 0 returns to IDLE.
- Latency: done rises 2 + 2*N_BITS edges after the edge that samples go (10 edges for N_BITS = 4).
- go held high through DONE does not restart; a new divide needs go low for at least one IDLE cycle.
- go is ignored while busy.
- Counter underflow cannot occur: the exit test follows every decrement.
- Correct arithmetic requires Y <= 8 with N_BITS = 4, because the datapath comparator is 4-bit. This is a datapath limit; the controller is unaffected.

Optional Feature:
DIV_CU_PULSE_DONE_EN
- Defined:
  - DONE/ERR last one cycle (done is a 1-cycle pulse), then the FSM returns to IDLE regardless of go.
  - An internal result_valid flag keeps s2 = s3 = 0 in IDLE after a successful divide until the next LOAD.
  - error stays high in IDLE until the next LOAD.
  - A go still high in IDLE restarts immediately.
- Undefined: level handshake as described in Behaviour.

Decomposition:
- Package div_pkg:
  - state enum typedef div_state_t;
  - CNT_W = 3;
  - DIV_DATA_W = 4;
  - control-bundle struct grouping the datapath control outputs.
- One natural sub-module, divider_cu_dec: a combinational state-to-control decoder, taking state, R_lt_Y and result_valid.

Test Plan:
- X = 7, Y = 2, go pulse held: 10 edges after go is sampled, done = 1 with Q = 3, R = 1; busy high for exactly those 10 cycles; error = 0.
- X = 13, Y = 8: Q = 1, R = 5; UPDATE Xshiftbit sequence is 0, 0, 0, 1.
- Y = 0, X = 9: ERR reached 2 edges after go; done = error = 1, Q = R = 0, no SHIFT state entered; go low returns to IDLE.
- rst pulled low during the second SHIFT of 15/4: all outputs return to reset values asynchronously; next go yields Q = 3, R = 3.
- go held high after DONE: no restart and done stays 1; go low for 1 cycle then high restarts. Under DIV_CU_PULSE_DONE_EN, done is a single cycle and the operation restarts back-to-back.
- Counter protocol check on every divide: exactly one load_cnt and N_BITS decrements; Cen is never asserted in IDLE, DONE or ERR.
